// File: rtl/shift_cmd_seq.sv
// Command sequencer for the downstream shift register: streams a captured word onto sl/sr/din one bit per clock.
// Optional even-parity trailer cycle is enabled by defining SHIFT_CMD_PARITY_EN.
module shift_cmd_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LENW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [LENW-1:0]  cmd_len,
   output logic             sl,
   output logic             sr,
   output logic             din,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [LENW-1:0] WIDTH_L = LENW'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic [LENW-1:0]  cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             sl_q, sl_d, sr_q, sr_d, din_q, din_d;
   logic             busy_q, busy_d, done_q, done_d, ready_q, ready_d;
   logic [LENW-1:0]  eff_len;
   logic [WIDTH-1:0] load_buf;
`ifdef SHIFT_CMD_PARITY_EN
   logic             par_q, par_d, psent_q, psent_d;
`endif

   function automatic logic head_bit(input logic [WIDTH-1:0] b, input logic dir);
      return dir ? b[0] : b[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] b, input logic dir);
      return dir ? (b >> 1) : (b << 1);
   endfunction

   always_comb begin
      eff_len = cmd_len;
      if (cmd_len == '0 || cmd_len > WIDTH_L) eff_len = WIDTH_L;
      // Left shifts emit MSB first from bit L-1, so pre-align the word to the top.
      load_buf = cmd_dir ? cmd_data : (cmd_data << (WIDTH_L - eff_len));
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      sl_d    = 1'b0;
      sr_d    = 1'b0;
      din_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ready_d = 1'b0;
`ifdef SHIFT_CMD_PARITY_EN
      par_d   = par_q;
      psent_d = psent_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d = SHIFT;
               dir_d   = cmd_dir;
               din_d   = head_bit(load_buf, cmd_dir);
               buf_d   = advance(load_buf, cmd_dir);
               cnt_d   = eff_len - LENW'(1);
               sl_d    = ~cmd_dir;
               sr_d    = cmd_dir;
               busy_d  = 1'b1;
`ifdef SHIFT_CMD_PARITY_EN
               par_d   = head_bit(load_buf, cmd_dir);
               psent_d = 1'b0;
`endif
            end else begin
               ready_d = 1'b1;
            end
         end
         SHIFT: begin
            busy_d = 1'b1;
            if (cnt_q != '0) begin
               din_d = head_bit(buf_q, dir_q);
               buf_d = advance(buf_q, dir_q);
               cnt_d = cnt_q - LENW'(1);
               sl_d  = ~dir_q;
               sr_d  = dir_q;
`ifdef SHIFT_CMD_PARITY_EN
               par_d = par_q ^ head_bit(buf_q, dir_q);
            end else if (!psent_q) begin
               din_d   = par_q;
               sl_d    = ~dir_q;
               sr_d    = dir_q;
               psent_d = 1'b1;
`endif
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         sl_q    <= 1'b0;
         sr_q    <= 1'b0;
         din_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
`ifdef SHIFT_CMD_PARITY_EN
         par_q   <= 1'b0;
         psent_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
`ifdef SHIFT_CMD_PARITY_EN
         par_q   <= par_d;
         psent_q <= psent_d;
`endif
      end
   end

   assign cmd_ready = ready_q;
   assign sl        = sl_q;
   assign sr        = sr_q;
   assign din       = din_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed bench for shift_cmd_seq with a behavioural model of the downstream 8-bit shift register.
// Expected din sequences and register contents switch when SHIFT_CMD_PARITY_EN is defined.
module tb_shift_cmd_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic       cmd_dir;
   logic [3:0] cmd_len;
   logic       sl, sr, din, busy, done;

   logic [7:0] q_ds;
   logic       ds_clr;
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   shift_cmd_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_len   (cmd_len),
      .sl        (sl),
      .sr        (sr),
      .din       (din),
      .busy      (busy),
      .done      (done)
   );

   // Downstream shift register: sl shifts din into bit 0, sr shifts din into bit 7.
   always @(posedge clk) begin
      if (ds_clr)  q_ds <= 8'h00;
      else if (sl) q_ds <= {q_ds[6:0], din};
      else if (sr) q_ds <= {din, q_ds[7:1]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ds();
      ds_clr = 1'b1;
      step();
      ds_clr = 1'b0;
   endtask

   // Issues one command and checks every output cycle; bits[nb-1] is the first din.
   task automatic run_cmd(input string name, input logic [7:0] data, input logic dir,
                          input logic [3:0] len, input int nb, input logic [8:0] bits,
                          input int change_at);
      int w;
      cmd_data  = data;
      cmd_dir   = dir;
      cmd_len   = len;
      cmd_valid = 1'b1;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 30) begin
         step();
         w++;
      end
      if (w >= 30) check({name, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      cmd_data  = ~data;
      cmd_dir   = ~dir;
      cmd_len   = 4'd1;
      for (int k = 0; k < nb; k++) begin
         if (k == change_at) begin
            cmd_valid = 1'b1;
            cmd_data  = 8'hFF;
            cmd_dir   = 1'b0;
            cmd_len   = 4'd12;
         end
         check($sformatf("%s_bit%0d", name, k), {26'd0, sl, sr, din, busy, cmd_ready, done},
               {26'd0, ~dir, dir, bits[nb-1-k], 1'b1, 1'b0, 1'b0});
         step();
      end
      check({name, "_done"}, {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'b000101);
      step();
      check({name, "_idle"}, {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'b000010);
   endtask

   initial begin
      ds_clr    = 1'b0;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      cmd_dir   = 1'b0;
      cmd_len   = 4'd0;
      step();
      step();
      check("reset_outs", {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'd0);
      reset = 1'b1;
      #1;
      check("release_ready_low", 32'(cmd_ready), 32'd0);
      step();
      check("release_outs", {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'b000010);

      clear_ds();
`ifdef SHIFT_CMD_PARITY_EN
      run_cmd("a5_left", 8'hA5, 1'b0, 4'd0, 9, 9'b1_0100_1010, -1);
      check("a5_q", 32'(q_ds), 32'h4A);
`else
      run_cmd("a5_left", 8'hA5, 1'b0, 4'd0, 8, 9'b0_1010_0101, -1);
      check("a5_q", 32'(q_ds), 32'hA5);
`endif

      clear_ds();
`ifdef SHIFT_CMD_PARITY_EN
      run_cmd("0f_right4", 8'h0F, 1'b1, 4'd4, 5, 9'b0_0001_1110, -1);
      check("0f_q", 32'(q_ds), 32'h78);
`else
      run_cmd("0f_right4", 8'h0F, 1'b1, 4'd4, 4, 9'b0_0000_1111, -1);
      check("0f_q", 32'(q_ds), 32'hF0);
`endif

`ifdef SHIFT_CMD_PARITY_EN
      run_cmd("3c_busy", 8'h3C, 1'b0, 4'd8, 9, 9'b0_0111_1000, 3);
      run_cmd("ff_clamp", 8'hFF, 1'b0, 4'd12, 9, 9'b1_1111_1110, -1);
      run_cmd("07_left3", 8'h07, 1'b0, 4'd3, 4, 9'b0_0000_1111, -1);
      run_cmd("01_right1", 8'h01, 1'b1, 4'd1, 2, 9'b0_0000_0011, -1);
`else
      run_cmd("3c_busy", 8'h3C, 1'b0, 4'd8, 8, 9'b0_0011_1100, 3);
      run_cmd("ff_clamp", 8'hFF, 1'b0, 4'd12, 8, 9'b0_1111_1111, -1);
      run_cmd("07_left3", 8'h07, 1'b0, 4'd3, 3, 9'b0_0000_0111, -1);
      run_cmd("01_right1", 8'h01, 1'b1, 4'd1, 1, 9'b0_0000_0001, -1);
`endif

      // Reset pulled low while the third bit is on the wire.
      cmd_data  = 8'hA5;
      cmd_dir   = 1'b0;
      cmd_len   = 4'd8;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      check("mid_bit2", {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'b101100);
      reset = 1'b0;
      #1;
      check("mid_reset_async", {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'd0);
      step();
      step();
      check("mid_reset_hold", {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'd0);
      reset = 1'b1;
      step();
      check("mid_release", {26'd0, sl, sr, din, busy, cmd_ready, done}, 32'b000010);
      clear_ds();
`ifdef SHIFT_CMD_PARITY_EN
      run_cmd("81_after_rst", 8'h81, 1'b0, 4'd0, 9, 9'b1_0000_0010, -1);
      check("81_q", 32'(q_ds), 32'h02);
`else
      run_cmd("81_after_rst", 8'h81, 1'b0, 4'd0, 8, 9'b0_1000_0001, -1);
      check("81_q", 32'(q_ds), 32'h81);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
